// File: rtl/cu_pkg.sv
// cu_pkg: shared opcodes, control encodings and types for the
// multicycle RV32I control unit.
package cu_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_U = 3'b010;
   localparam logic [2:0] IMM_B = 3'b101;
   localparam logic [2:0] IMM_J = 3'b110;

   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_PC4 = 2'b10;

   localparam logic [1:0] BR_COND = 2'b01;
   localparam logic [4:0] BR_NONE = 5'b00000;
   localparam logic [4:0] BR_JUMP = 5'b11111;

   localparam logic [1:0] TC_NONE    = 2'b00;
   localparam logic [1:0] TC_ILLEGAL = 2'b01;
   localparam logic [1:0] TC_IMEM    = 2'b10;
   localparam logic [1:0] TC_DMEM    = 2'b11;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_FETCH  = 3'd1;
   localparam logic [2:0] ST_DECODE = 3'd2;
   localparam logic [2:0] ST_EXEC   = 3'd3;
   localparam logic [2:0] ST_MEM    = 3'd4;
   localparam logic [2:0] ST_WB     = 3'd5;
   localparam logic [2:0] ST_TRAP   = 3'd6;

   typedef enum logic [2:0] {
      S_IDLE   = ST_IDLE,
      S_FETCH  = ST_FETCH,
      S_DECODE = ST_DECODE,
      S_EXEC   = ST_EXEC,
      S_MEM    = ST_MEM,
      S_WB     = ST_WB,
      S_TRAP   = ST_TRAP
   } state_t;

   typedef struct packed {
      logic [2:0] imm_src;
      logic       alua_src;
      logic       alub_src;
      logic [4:0] br_op;
      logic [3:0] alu_op;
      logic [2:0] dm_ctrl;
      logic [1:0] wb_src;
   } ctrl_t;

endpackage

// File: rtl/cu_decode.sv
// cu_decode: combinational RV32I decode of the latched IR into
// datapath controls and instruction class flags.
module cu_decode
   import cu_pkg::*;
(
   input  logic [31:0] ir,
   output ctrl_t       ctrl,
   output logic        is_legal,
   output logic        is_load,
   output logic        is_store,
   output logic        is_branch,
   output logic        writes_rd
);

   logic [6:0] op;
   logic [2:0] f3;
   logic       f7b5;
   logic       unused_bits;

   assign op   = ir[6:0];
   assign f3   = ir[14:12];
   assign f7b5 = ir[30];
   assign unused_bits = ^{ir[31], ir[29:15], ir[11:7]};

   always_comb begin
      ctrl          = '0;
      ctrl.alub_src = 1'b1;
      is_legal      = 1'b1;
      is_load       = 1'b0;
      is_store      = 1'b0;
      is_branch     = 1'b0;
      unique case (op)
         OP_R: begin
            ctrl.alub_src = 1'b0;
            ctrl.alu_op   = {f7b5, f3};
         end
         OP_I: begin
            ctrl.imm_src = IMM_I;
            ctrl.alu_op  = {(f3 == 3'b101) & f7b5, f3};
         end
         OP_LOAD: begin
            is_load      = 1'b1;
            ctrl.imm_src = IMM_I;
            ctrl.wb_src  = WB_MEM;
            ctrl.dm_ctrl = f3;
         end
         OP_STORE: begin
            is_store     = 1'b1;
            ctrl.imm_src = IMM_S;
            ctrl.dm_ctrl = f3;
         end
         OP_BRANCH: begin
            is_branch     = 1'b1;
            ctrl.imm_src  = IMM_B;
            ctrl.br_op    = {BR_COND, f3};
            ctrl.alua_src = 1'b1;
         end
         OP_JAL: begin
            ctrl.imm_src  = IMM_J;
            ctrl.br_op    = BR_JUMP;
            ctrl.alua_src = 1'b1;
            ctrl.wb_src   = WB_PC4;
         end
         OP_JALR: begin
            ctrl.imm_src = IMM_I;
            ctrl.br_op   = BR_JUMP;
            ctrl.wb_src  = WB_PC4;
         end
         OP_LUI: begin
            ctrl.imm_src = IMM_U;
         end
         OP_AUIPC: begin
            ctrl.imm_src  = IMM_U;
            ctrl.alua_src = 1'b1;
         end
         default: begin
            ctrl     = '0;
            is_legal = 1'b0;
         end
      endcase
   end

   assign writes_rd = is_legal & ~is_store & ~is_branch;

endmodule

// File: rtl/cu_multicycle.sv
// cu_multicycle: multicycle RV32I control unit with IR, memory
// handshakes, wait-state timeout and trap handling.
module cu_multicycle
   import cu_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15,
   parameter int TO_W        = 4,
   parameter bit TRAP_EN     = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] Instr,
   input  logic        IMemReady,
   input  logic        DMemReady,
   output logic        IMemReq,
   output logic        IRWr,
   output logic        DMemReq,
   output logic        PCWr,
   output logic [2:0]  ImmSrc,
   output logic        ALUASrc,
   output logic        ALUBSrc,
   output logic        RUWr,
   output logic [4:0]  BrOp,
   output logic [3:0]  ALUOp,
   output logic        DMWr,
   output logic [2:0]  DMCtrl,
   output logic [1:0]  RUDataWrSrc,
   output logic        Trap,
   output logic [1:0]  TrapCause,
   output logic [2:0]  State
);

   state_t          state, nxt;
   logic [31:0]     ir;
   logic [TO_W-1:0] cnt;
   logic [1:0]      cause, nxt_cause;
   ctrl_t           dec, ctrl;
   logic            legal, is_ld, is_st, is_br, wr_rd;
   logic            to_hit, waiting, active, st_done;

   cu_decode u_dec (
      .ir        (ir),
      .ctrl      (dec),
      .is_legal  (legal),
      .is_load   (is_ld),
      .is_store  (is_st),
      .is_branch (is_br),
      .writes_rd (wr_rd)
   );

   assign to_hit  = (MEM_TIMEOUT != 0) && (cnt == TO_W'(MEM_TIMEOUT));
   assign waiting = (state == S_FETCH && !IMemReady)
                 || (state == S_MEM && !DMemReady);

   always_comb begin
      nxt       = state;
      nxt_cause = cause;
      unique case (state)
         S_IDLE: nxt = S_FETCH;
         S_FETCH: begin
            if (IMemReady) begin
               nxt = S_DECODE;
            end else if (to_hit) begin
               nxt       = S_TRAP;
               nxt_cause = TC_IMEM;
            end
         end
         S_DECODE: begin
            if (legal) begin
               nxt = S_EXEC;
            end else if (TRAP_EN) begin
               nxt       = S_TRAP;
               nxt_cause = TC_ILLEGAL;
            end else begin
               nxt = S_FETCH;
            end
         end
         S_EXEC: begin
            if (is_br)               nxt = S_FETCH;
            else if (is_ld || is_st) nxt = S_MEM;
            else                     nxt = S_WB;
         end
         S_MEM: begin
            if (DMemReady) begin
               nxt = is_st ? S_FETCH : S_WB;
            end else if (to_hit) begin
               nxt       = S_TRAP;
               nxt_cause = TC_DMEM;
            end
         end
         S_WB:    nxt = S_FETCH;
         S_TRAP:  nxt = S_TRAP;
         default: nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         cause <= TC_NONE;
         cnt   <= '0;
         ir    <= '0;
      end else begin
         state <= nxt;
         cause <= nxt_cause;
         if (IRWr) ir <= Instr;
         // any state change clears, so FETCH/MEM always start at 0
         if (nxt != state)  cnt <= '0;
         else if (waiting)  cnt <= cnt + 1'b1;
      end
   end

   assign active  = (state == S_EXEC) || (state == S_MEM)
                 || (state == S_WB);
   assign ctrl    = active ? dec : '0;
   assign st_done = (state == S_MEM) && is_st && DMemReady;

   assign IMemReq     = (state == S_FETCH);
   assign IRWr        = IMemReq && IMemReady;
   assign DMemReq     = (state == S_MEM);
   // store write commits on the completing cycle only
   assign DMWr        = st_done;
   assign RUWr        = (state == S_WB) && wr_rd;
   assign PCWr        = (state == S_DECODE && !legal && !TRAP_EN)
                     || (state == S_EXEC && is_br)
                     || st_done
                     || (state == S_WB);
   assign ImmSrc      = ctrl.imm_src;
   assign ALUASrc     = ctrl.alua_src;
   assign ALUBSrc     = ctrl.alub_src;
   assign BrOp        = ctrl.br_op;
   assign ALUOp       = ctrl.alu_op;
   assign DMCtrl      = ctrl.dm_ctrl;
   assign RUDataWrSrc = ctrl.wb_src;
   assign Trap        = (state == S_TRAP);
   assign TrapCause   = cause;
   assign State       = state;

endmodule
